// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS32 bus CPU: opcodes, function
// codes, FSM states and fixed addresses.
package mips_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] HALT_ADDR    = 32'h0000_0000;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        MEM    = 2'd2,
        HALTED = 2'd3
    } state_e;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 general-purpose register file: two combinational read ports, one
// synchronous write port, $0 hardwired to zero, v0 tap for observation.
module mips_regfile
    import mips_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [4:0]  ra_addr_i,
    input  logic [4:0]  rb_addr_i,
    output logic [31:0] ra_data_o,
    output logic [31:0] rb_data_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i,
    output logic [31:0] v0_o
);

    logic [31:0] regs_q [32];

    assign ra_data_o = (ra_addr_i == 5'd0) ? 32'h0 : regs_q[ra_addr_i];
    assign rb_data_o = (rb_addr_i == 5'd0) ? 32'h0 : regs_q[rb_addr_i];
    assign v0_o      = regs_q[2];

    // Register array; writes to $0 are dropped so it stays zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else if (we_i && (wa_i != 5'd0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

endmodule

// File: rtl/mips_bus_cpu.sv
// Multi-cycle non-pipelined MIPS32 core on one shared Avalon-style bus.
// FETCH -> EXEC (-> MEM for LW/SW); halts when the next PC to fetch is 0.
module mips_bus_cpu
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    output logic [31:0] address,
    output logic        write,
    output logic        read,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        ds_q, ds_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] maddr_q, maddr_d;
    logic [31:0] sdata_q, sdata_d;

    logic [5:0]  op_s, fn_s;
    logic [4:0]  rs_s, rt_s, rd_s, sh_s;
    logic [31:0] simm_s, zimm_s, rs_val_s, rt_val_s, pc_plus4_s;
    logic        alu_we_s, br_s, is_lw_s, is_sw_s;
    logic [4:0]  alu_wa_s;
    logic [31:0] alu_res_s, br_tgt_s;
    logic [31:0] npc_s, tgt_next_s;
    logic        ds_next_s;
    logic        rf_we_s;
    logic [4:0]  rf_wa_s;
    logic [31:0] rf_wd_s;

    assign op_s       = ir_q[31:26];
    assign rs_s       = ir_q[25:21];
    assign rt_s       = ir_q[20:16];
    assign rd_s       = ir_q[15:11];
    assign sh_s       = ir_q[10:6];
    assign fn_s       = ir_q[5:0];
    assign simm_s     = sext16(ir_q[15:0]);
    assign zimm_s     = {16'h0, ir_q[15:0]};
    assign pc_plus4_s = pc_q + 32'd4;
    assign is_lw_s    = (op_s == OP_LW);
    assign is_sw_s    = (op_s == OP_SW);

    mips_regfile u_regfile (
        .clk_i     (clk),
        .rst_ni    (reset),
        .ra_addr_i (rs_s),
        .rb_addr_i (rt_s),
        .ra_data_o (rs_val_s),
        .rb_data_o (rt_val_s),
        .we_i      (rf_we_s),
        .wa_i      (rf_wa_s),
        .wd_i      (rf_wd_s),
        .v0_o      (register_v0)
    );

    // Decode and ALU for the instruction held in IR.
    always_comb begin
        alu_we_s  = 1'b0;
        alu_wa_s  = rt_s;
        alu_res_s = 32'h0;
        br_s      = 1'b0;
        br_tgt_s  = pc_plus4_s + {simm_s[29:0], 2'b00};
        case (op_s)
            OP_SPECIAL: begin
                alu_wa_s = rd_s;
                alu_we_s = 1'b1;
                case (fn_s)
                    FN_ADDU: alu_res_s = rs_val_s + rt_val_s;
                    FN_SUBU: alu_res_s = rs_val_s - rt_val_s;
                    FN_AND:  alu_res_s = rs_val_s & rt_val_s;
                    FN_OR:   alu_res_s = rs_val_s | rt_val_s;
                    FN_XOR:  alu_res_s = rs_val_s ^ rt_val_s;
                    FN_SLT:  alu_res_s = {31'd0, $signed(rs_val_s) < $signed(rt_val_s)};
                    FN_SLTU: alu_res_s = {31'd0, rs_val_s < rt_val_s};
                    FN_SLL:  alu_res_s = rt_val_s << sh_s;
                    FN_SRL:  alu_res_s = rt_val_s >> sh_s;
                    FN_SRA:  alu_res_s = $signed(rt_val_s) >>> sh_s;
                    FN_JR: begin
                        alu_we_s = 1'b0;
                        br_s     = 1'b1;
                        br_tgt_s = rs_val_s;
                    end
                    default: alu_we_s = 1'b0;
                endcase
            end
            OP_ADDIU: begin alu_we_s = 1'b1; alu_res_s = rs_val_s + simm_s; end
            OP_SLTI:  begin alu_we_s = 1'b1; alu_res_s = {31'd0, $signed(rs_val_s) < $signed(simm_s)}; end
            OP_SLTIU: begin alu_we_s = 1'b1; alu_res_s = {31'd0, rs_val_s < simm_s}; end
            OP_ANDI:  begin alu_we_s = 1'b1; alu_res_s = rs_val_s & zimm_s; end
            OP_ORI:   begin alu_we_s = 1'b1; alu_res_s = rs_val_s | zimm_s; end
            OP_XORI:  begin alu_we_s = 1'b1; alu_res_s = rs_val_s ^ zimm_s; end
            OP_LUI:   begin alu_we_s = 1'b1; alu_res_s = {ir_q[15:0], 16'h0}; end
            OP_BEQ:   br_s = (rs_val_s == rt_val_s);
            OP_BNE:   br_s = (rs_val_s != rt_val_s);
            OP_J: begin
                br_s     = 1'b1;
                br_tgt_s = {pc_plus4_s[31:28], ir_q[25:0], 2'b00};
            end
            default: alu_we_s = 1'b0;
        endcase
    end

    // A pending delay-slot target wins; a new branch only arms the slot.
    always_comb begin
        npc_s      = pc_plus4_s;
        ds_next_s  = 1'b0;
        tgt_next_s = tgt_q;
        if (ds_q) begin
            npc_s = tgt_q;
        end else if (br_s) begin
            ds_next_s  = 1'b1;
            tgt_next_s = br_tgt_s;
        end else begin
            npc_s = pc_plus4_s;
        end
    end

    // FSM next state, PC sequencing and register write-back.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ds_d    = ds_q;
        tgt_d   = tgt_q;
        maddr_d = maddr_q;
        sdata_d = sdata_q;
        rf_we_s = 1'b0;
        rf_wa_s = 5'd0;
        rf_wd_s = 32'h0;
        case (state_q)
            FETCH: begin
                if (!waitrequest) begin
                    ir_d    = readdata;
                    state_d = EXEC;
                end else begin
                    state_d = FETCH;
                end
            end
            EXEC: begin
                pc_d  = npc_s;
                ds_d  = ds_next_s;
                tgt_d = tgt_next_s;
                if (is_lw_s || is_sw_s) begin
                    maddr_d = rs_val_s + simm_s;
                    sdata_d = rt_val_s;
                    state_d = MEM;
                end else begin
                    rf_we_s = alu_we_s;
                    rf_wa_s = alu_wa_s;
                    rf_wd_s = alu_res_s;
                    state_d = (npc_s == HALT_ADDR) ? HALTED : FETCH;
                end
            end
            MEM: begin
                if (!waitrequest) begin
                    rf_we_s = is_lw_s;
                    rf_wa_s = rt_s;
                    rf_wd_s = readdata;
                    state_d = (pc_q == HALT_ADDR) ? HALTED : FETCH;
                end else begin
                    state_d = MEM;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = FETCH;
        endcase
    end

    // Bus outputs come from registered state only; reset forces them idle.
    always_comb begin
        read       = 1'b0;
        write      = 1'b0;
        address    = 32'h0;
        byteenable = 4'b0000;
        writedata  = 32'h0;
        if (reset) begin
            case (state_q)
                FETCH: begin
                    read       = 1'b1;
                    address    = {pc_q[31:2], 2'b00};
                    byteenable = 4'b1111;
                end
                MEM: begin
                    address    = {maddr_q[31:2], 2'b00};
                    byteenable = 4'b1111;
                    read       = is_lw_s;
                    write      = is_sw_s;
                    writedata  = is_sw_s ? sdata_q : 32'h0;
                end
                default: begin
                    read = 1'b0;
                end
            endcase
        end else begin
            read = 1'b0;
        end
    end

    assign active = reset && (state_q != HALTED);

    // Architectural state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_VECTOR;
            ir_q    <= 32'h0;
            ds_q    <= 1'b0;
            tgt_q   <= 32'h0;
            maddr_q <= 32'h0;
            sdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ds_q    <= ds_d;
            tgt_q   <= tgt_d;
            maddr_q <= maddr_d;
            sdata_q <= sdata_d;
        end
    end

endmodule

// File: tb/tb_mips_bus_cpu.sv
// Scoreboard bench for mips_bus_cpu: directed programs push the expected bus
// transactions and halt state; a monitor checks every completed access.
module tb_mips_bus_cpu;

    localparam logic [31:0] BASE = 32'hBFC0_0000;

    logic        clk;
    logic        reset;
    logic        active;
    logic [31:0] register_v0;
    logic [31:0] address;
    logic        write;
    logic        read;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    mips_bus_cpu dut (
        .clk         (clk),
        .reset       (reset),
        .active      (active),
        .register_v0 (register_v0),
        .address     (address),
        .write       (write),
        .read        (read),
        .waitrequest (waitrequest),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .readdata    (readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: 128 words at BASE, programmable wait states per access.
    logic [31:0] mem [128];
    logic [31:0] img [128];
    logic        ld_we;
    logic [6:0]  ld_idx;
    logic [31:0] ld_data;
    int          wcnt;
    int          wait_n;
    logic        in_region;

    assign in_region   = (address[31:9] == 23'h5FE000);
    assign readdata    = in_region ? mem[address[8:2]] : 32'h0;
    assign waitrequest = (read || write) && (wcnt < wait_n);

    always @(posedge clk) begin
        if (ld_we) mem[ld_idx] <= ld_data;
        else if (write && !waitrequest && in_region) mem[address[8:2]] <= writedata;
        if ((read || write) && waitrequest) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    typedef struct {
        int          kind;   // 0 read, 1 write, 2 halt
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } ev_t;

    ev_t sb[$];
    int  tests = 0;
    int  fails = 0;
    int  active_cycles;
    bit  halt_seen;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
        end
    endtask

    task automatic put(input int idx, input logic [31:0] w);
        ld_idx  = 7'(idx);
        ld_data = w;
        img[idx] = w;
        ld_we   = 1'b1;
        @(posedge clk);
        #1 ld_we = 1'b0;
    endtask

    task automatic exp_fetch(input int idx);
        sb.push_back('{0, BASE + 32'(idx * 4), img[idx], 0});
    endtask

    task automatic exp_rd(input logic [31:0] a, input logic [31:0] d);
        sb.push_back('{0, a, d, 0});
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
        sb.push_back('{1, a, d, 0});
    endtask

    task automatic exp_halt(input logic [31:0] v0, input int cyc);
        sb.push_back('{2, 32'h0, v0, cyc});
    endtask

    // Monitor: checks completed accesses, stall stability and halt.
    initial begin
        logic        prev_act, stall_prev, s_rd, s_wr;
        logic [31:0] s_addr, s_wd;
        ev_t         e;
        prev_act = 1'b0;
        stall_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_act   = 1'b0;
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    chk("stall_addr", address, s_addr);
                    chk("stall_read", 32'(read), 32'(s_rd));
                    chk("stall_write", 32'(write), 32'(s_wr));
                    chk("stall_wdata", writedata, s_wd);
                end
                if ((read || write) && !waitrequest) begin
                    chk("rd_wr_exclusive", 32'(read && write), 32'd0);
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL sb_unexpected: got access at 0x%08h, required none", address);
                    end else begin
                        e = sb.pop_front();
                        chk("bus_kind", 32'(write), 32'(e.kind));
                        chk("bus_addr", address, e.addr);
                        chk("bus_data", write ? writedata : readdata, e.data);
                        chk("bus_be", 32'(byteenable), 32'hF);
                    end
                end
                if (active) active_cycles++;
                if (prev_act && !active) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL halt_unexpected: got halt, required more activity");
                    end else begin
                        e = sb.pop_front();
                        chk("halt_kind", 32'(e.kind), 32'd2);
                        chk("halt_v0", register_v0, e.data);
                        chk("halt_cycles", 32'(active_cycles), 32'(e.cyc));
                    end
                    halt_seen = 1'b1;
                end
                stall_prev = (read || write) && waitrequest;
                s_addr = address;
                s_rd   = read;
                s_wr   = write;
                s_wd   = writedata;
                prev_act = active;
            end
        end
    end

    task automatic run(input int wn, input bit first_chk);
        wait_n        = wn;
        active_cycles = 0;
        halt_seen     = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        if (first_chk) begin
            @(negedge clk);
            chk("first_active", 32'(active), 32'd1);
            chk("first_read", 32'(read), 32'd1);
            chk("first_write", 32'(write), 32'd0);
            chk("first_addr", address, BASE);
            chk("first_be", 32'(byteenable), 32'hF);
        end
        for (int c = 0; c < 400 && !halt_seen; c++) @(negedge clk);
        if (!halt_seen) begin
            tests++;
            fails++;
            $display("FAIL halt_timeout: got no halt, required halt within 400 cycles");
        end
        repeat (3) @(negedge clk);
        chk("post_halt_active", 32'(active), 32'd0);
        chk("post_halt_read", 32'(read), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        sb.delete();
        reset = 1'b0;
    endtask

    initial begin
        reset  = 1'b0;
        ld_we  = 1'b0;
        ld_idx = 7'd0;
        ld_data = 32'h0;
        wait_n = 0;
        for (int i = 0; i < 128; i++) img[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_read", 32'(read), 32'd0);
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_addr", address, 32'h0);
        chk("rst_be", 32'(byteenable), 32'h0);
        chk("rst_wdata", writedata, 32'h0);
        chk("rst_v0", register_v0, 32'h0);

        // XOR program, zero wait states then three wait states per access
        for (int pass = 0; pass < 2; pass++) begin
            put(0, 32'h3C03BFC0);
            put(1, 32'h8C690004);
            put(2, 32'h8C6A0008);
            put(3, 32'h00000008);
            put(4, 32'h012A1026);
            exp_fetch(0);
            exp_fetch(1); exp_rd(BASE + 32'h4, 32'h8C690004);
            exp_fetch(2); exp_rd(BASE + 32'h8, 32'h8C6A0008);
            exp_fetch(3);
            exp_fetch(4);
            exp_halt(32'h0003000C, (pass == 0) ? 12 : 33);
            run((pass == 0) ? 0 : 3, pass == 0);
        end

        // Delay slot after jr zero executes
        put(0, 32'h2402FFFF);
        put(1, 32'h00000008);
        put(2, 32'h24420002);
        exp_fetch(0); exp_fetch(1); exp_fetch(2);
        exp_halt(32'h00000001, 6);
        run(0, 1'b0);

        // Store then load
        put(0, 32'h3C03BFC0);
        put(1, 32'h24080055);
        put(2, 32'hAC680100);
        put(3, 32'h8C620100);
        put(4, 32'h00000008);
        put(5, 32'h00000000);
        exp_fetch(0); exp_fetch(1);
        exp_fetch(2); exp_wr(BASE + 32'h100, 32'h00000055);
        exp_fetch(3); exp_rd(BASE + 32'h100, 32'h00000055);
        exp_fetch(4); exp_fetch(5);
        exp_halt(32'h00000055, 14);
        run(0, 1'b0);

        // beq taken: delay slot runs, following instruction is skipped
        put(0, 32'h10000002);
        put(1, 32'h24020007);
        put(2, 32'h24020099);
        put(3, 32'h00000008);
        put(4, 32'h24420001);
        exp_fetch(0); exp_fetch(1); exp_fetch(3); exp_fetch(4);
        exp_halt(32'h00000008, 8);
        run(0, 1'b0);

        // Shifts, signed/unsigned compares, bne, subu, j, xori, andi
        put(0,  32'h2408FFF8);
        put(1,  32'h00084843);
        put(2,  32'h00085702);
        put(3,  32'h010A102A);
        put(4,  32'h0148582B);
        put(5,  32'h15600002);
        put(6,  32'h00021100);
        put(7,  32'h3402DEAD);
        put(8,  32'h00491023);
        put(9,  32'h0BF0000B);
        put(10, 32'h3842FFFF);
        put(11, 32'h00000008);
        put(12, 32'h30420F0F);
        for (int i = 0; i < 13; i++) begin
            if (i != 7) exp_fetch(i);
        end
        exp_halt(32'h00000F0B, 24);
        run(0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mips_bus_cpu.md
# mips_bus_cpu

Multi-cycle, non-pipelined MIPS32 little-endian CPU core with a single Avalon-style memory bus shared by instruction fetch and data access. It is the top-level processor of the design and connects directly to a memory model such as mips_cpu_ram. It executes a reduced integer ISA, runs from the reset vector, and halts when control transfers to address 0. On halt it exposes register $2 (v0) for checking.

## Interface
- No parameters. Reset vector 0xBFC00000 and halt address 0x00000000 are fixed constants.
- clk  in  1  single system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- active  out  1  high while executing; low in reset and after halt.
- register_v0  out  32  continuous copy of GPR $2.
- address  out  32  word-aligned byte address; bits [1:0] are always 0.
- write  out  1  write strobe.
- read  out  1  read strobe; never high in the same cycle as write.
- waitrequest  in  1  memory stall; the current read or write is held unchanged while high.
- writedata  out  32  store data.
- byteenable  out  4  active byte lanes; bit0 = bits [7:0].
- readdata  in  32  read data; valid in the cycle where read=1 and waitrequest=0.

## Operation
- Supported ISA:
  - R-type: ADDU, SUBU, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, JR.
  - I-type: ADDIU, ANDI, ORI, XORI, SLTI, SLTIU, LUI, LW, SW, BEQ, BNE.
  - J-type: J.
- Unsupported opcodes execute as NOP.
- $0 reads as 0 and ignores writes. All arithmetic is modulo 2^32 with no overflow traps.
- Immediates: ANDI, ORI and XORI zero-extend; all others sign-extend. Shifts use the shamt field.
- JR, J, BEQ and BNE have one branch-delay slot. The instruction after the branch always executes. The target is PC+4+(imm<<2) for branches and {PC+4[31:28], idx, 2'b00} for J.
- Halt: when the next PC to fetch equals 0 after a delay slot completes:
  - no fetch is issued;
  - active drops to 0;
  - the FSM enters HALTED and stays there until reset.
- LW and SW addresses must be word-aligned. Misaligned addresses have unspecified results and are not checked.
- States:
  - FETCH: read=1, address=PC, byteenable=1111; holds while waitrequest=1; latches IR when waitrequest=0.
  - EXEC: decode, read registers, run the ALU; non-memory instructions write back and update PC here, then go to FETCH or HALTED.
  - MEM: LW asserts read; SW asserts write with writedata=rt; byteenable=1111 in both; holds while waitrequest=1; LW writes back on completion.
  - HALTED: terminal state.

## Timing
- Reset asserted:
  - PC=0xBFC00000, all GPRs=0, FSM=FETCH, delay-slot flag cleared;
  - active=0, read=0, write=0, address=0, byteenable=0000, writedata=0.
- In the first cycle after reset deasserts, the bus shows active=1, read=1, write=0, address=0xBFC00000, byteenable=1111.
- Latency with zero wait states:
  - 2 cycles for ALU, branch and jump instructions (FETCH, EXEC);
  - 3 cycles for LW and SW (FETCH, EXEC, MEM).
- Each waitrequest cycle adds one cycle. Bus outputs stay stable throughout a stall.
- Reset asserted mid-transaction aborts the transaction immediately. Bus strobes drop asynchronously.
- register_v0 updates on the same edge as the write-back.

## Structure
- Shared package mips_pkg holds:
  - opcode and funct localparams;
  - the state enum (FETCH, EXEC, MEM, HALTED);
  - RESET_VECTOR.
- Sub-module mips_regfile: 32x32 registers, two combinational read ports, one synchronous write port, $0 hardwired to 0, v0 tap output.
- ALU and decode stay inline in the top module.
- mips_cpu_ram is a bench-side model. It is initialised from a hex file mapped at 0xBFC00000 and may insert random waitrequest cycles.

## Test plan
- Reset check: pulse reset, release it, sample on the next negedge -> active=1, address=0xBFC00000, read=1, write=0, byteenable=1111.
- XOR program (lui v1,0xBFC0; lw t1,4(v1); lw t2,8(v1); jr zero; xor v0,t1,t2) -> loaded words 0x8C690004 and 0x8C6A0008; active falls; v0=0x0003000C.
- ALU and delay slot: addiu v0,zero,-1; jr zero; addiu v0,v0,2 -> v0=0x00000001 at halt.
- Store then load: addiu t0,zero,0x55; sw t0,0x100(v1); lw v0,0x100(v1); jr zero; nop -> SW cycle shows write=1, writedata=0x55, byteenable=1111; v0=0x55.
- Wait states: rerun the XOR program with waitrequest high for 3 cycles on each access -> address, read and write held stable; same v0.
- Branch: beq zero,zero,+2 with its delay slot executed and one skipped instruction that writes v0 -> the skipped write does not occur.
